// File: rtl/uart_recv_if.sv
//==============================================================================
// Module      : uart_recv_if
// Description : Serial-in / byte-out signal bundle of the 8N1 UART receiver.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

interface uart_recv_if;
    logic       RXD;
    logic [7:0] DATA;
    logic       DATA_READY;
    logic       FRAME_ERR;
    logic       IDLE;

    // Line/consumer side: drives the pin and takes the received bytes.
    modport master (
        output RXD,
        input  DATA,
        input  DATA_READY,
        input  FRAME_ERR,
        input  IDLE
    );

    // Receiver side.
    modport slave (
        input  RXD,
        output DATA,
        output DATA_READY,
        output FRAME_ERR,
        output IDLE
    );
endinterface

`default_nettype wire

// File: rtl/uart_recv.sv
//==============================================================================
// Module      : uart_recv
// Description : 8N1 UART receiver with 3-sample mid-bit majority vote,
//               one-cycle DATA_READY / FRAME_ERR strobes.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module uart_recv #(
    parameter int CLKS_PER_BIT = 26
) (
    input  logic        CLK,
    input  logic        RST,
    uart_recv_if.slave  bus
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int c_CW = $clog2(CLKS_PER_BIT);

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_VOTE0    = c_CW'(HALF - 1);
    localparam logic [c_CW-1:0] c_VOTE1    = c_CW'(HALF);
    localparam logic [c_CW-1:0] c_VOTE2    = c_CW'(HALF + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_rx_p;
    logic [1:0]        r_flush;
    logic              r_armed;
    logic              r_v0;
    logic              r_v1;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic [7:0]        r_data;
    logic [7:0]        w_data_nxt;
    logic              r_ready;
    logic              w_ready_nxt;
    logic              r_ferr;
    logic              w_ferr_nxt;

    logic              w_fall;
    logic              w_vote;
    logic              w_bit;
    logic              w_wrap;

    // Synchroniser, edge flop and vote captures.
    // r_armed only rises once rx_s carries a real sampled high, so a line
    // that is already low when reset releases never looks like a 1->0 edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rx_p  <= 1'b1;
            r_flush <= 2'b00;
            r_armed <= 1'b0;
            r_v0    <= 1'b1;
            r_v1    <= 1'b1;
        end else begin
            r_sync1 <= bus.RXD;
            r_sync2 <= r_sync1;
            r_rx_p  <= r_sync2;
            r_flush <= {r_flush[0], 1'b1};
            if (r_flush[1] && r_sync2)
                r_armed <= 1'b1;
            if (r_cnt == c_VOTE0)
                r_v0 <= r_sync2;
            if (r_cnt == c_VOTE1)
                r_v1 <= r_sync2;
        end
    end

    assign w_fall = r_armed & r_rx_p & ~r_sync2;
    assign w_vote = (r_cnt == c_VOTE2);
    assign w_wrap = (r_cnt == c_CNT_LAST);
    assign w_bit  = (r_v0 & r_v1) | (r_v0 & r_sync2) | (r_v1 & r_sync2);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_ready <= w_ready_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_wrap ? '0 : r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_ready_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall)
                    w_state_nxt = S_START;
            end
            S_START: begin
                if (w_vote && w_bit) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wrap) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_vote)
                    w_shift_nxt = {w_bit, r_shift[7:1]};
                if (w_wrap) begin
                    if (r_idx == 3'd7)
                        w_state_nxt = S_STOP;
                    else
                        w_idx_nxt = r_idx + 3'd1;
                end
            end
            S_STOP: begin
                // Leave at mid-stop so a start edge right after a 1-bit stop is seen.
                if (w_vote) begin
                    if (w_bit) begin
                        w_data_nxt  = r_shift;
                        w_ready_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_BRK;
                    end
                end
            end
            S_BRK: begin
                w_cnt_nxt = '0;
                if (r_sync2)
                    w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.DATA       = r_data;
    assign bus.DATA_READY = r_ready;
    assign bus.FRAME_ERR  = r_ferr;
    assign bus.IDLE       = (r_state == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_recv.sv
//==============================================================================
// Module      : tb_uart_recv
// Description : Directed self-checking bench for uart_recv.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_uart_recv;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_recv_if bus ();

    uart_recv #(.CLKS_PER_BIT(26)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    int         ready_cnt      = 0;
    int         ferr_cnt       = 0;
    int         both_cnt       = 0;
    int         wide_cnt       = 0;
    int         last_ready_cyc = 0;
    logic       prev_ready     = 1'b0;
    logic       prev_ferr      = 1'b0;
    logic [7:0] rx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.DATA_READY === 1'b1) begin
            rx_q.push_back(bus.DATA);
            ready_cnt      <= ready_cnt + 1;
            last_ready_cyc <= cyc;
            if (prev_ready) wide_cnt <= wide_cnt + 1;
        end
        if (bus.FRAME_ERR === 1'b1) begin
            ferr_cnt <= ferr_cnt + 1;
            if (prev_ferr) wide_cnt <= wide_cnt + 1;
        end
        if (bus.DATA_READY === 1'b1 && bus.FRAME_ERR === 1'b1)
            both_cnt <= both_cnt + 1;
        prev_ready <= (bus.DATA_READY === 1'b1);
        prev_ferr  <= (bus.FRAME_ERR === 1'b1);
    end

    // Drives one 10-slot frame; slot boundaries at round(k*p100/100) clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int p100,
                              input int glitch_slot, output int start_cyc);
        logic [9:0] fr;
        int end_c, k, lo, hi, mid;
        logic lvl;
        fr    = {stop, b, 1'b0};
        end_c = (10 * p100 + 50) / 100;
        k     = 0;
        start_cyc = 0;
        for (int c = 0; c < end_c; c++) begin
            while ((((k + 1) * p100 + 50) / 100) <= c) k++;
            lo  = (k * p100 + 50) / 100;
            hi  = ((k + 1) * p100 + 50) / 100;
            mid = (lo + hi) / 2;
            lvl = fr[k];
            if (k == glitch_slot && c == mid) lvl = 1'b0;
            @(negedge clk);
            bus.RXD = lvl;
            if (c == 0) start_cyc = cyc;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total++; if (bus.DATA !== 8'h00) $display("FAIL reset_data: got %h expected 00", bus.DATA); else n_pass++;
        n_total++; if (bus.DATA_READY !== 1'b0) $display("FAIL reset_ready: got %b expected 0", bus.DATA_READY); else n_pass++;
        n_total++; if (bus.FRAME_ERR !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", bus.FRAME_ERR); else n_pass++;
        n_total++; if (bus.IDLE !== 1'b1) $display("FAIL reset_idle: got %b expected 1", bus.IDLE); else n_pass++;
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single();
        int r0, f0, sc;
        r0 = ready_cnt; f0 = ferr_cnt; rx_q.delete();
        send_frame(8'hA5, 1'b1, 2600, -1, sc);
        bus.RXD = 1'b1;
        repeat (20) @(negedge clk);
        n_total++; if (ready_cnt - r0 != 1) $display("FAIL single_count: got %0d expected 1", ready_cnt - r0); else n_pass++;
        n_total++; if (bus.DATA !== 8'hA5) $display("FAIL single_data: got %h expected a5", bus.DATA); else n_pass++;
        n_total++; if (ferr_cnt != f0) $display("FAIL single_ferr: got %0d expected 0", ferr_cnt - f0); else n_pass++;
        n_total++; if (last_ready_cyc - sc != 252) $display("FAIL single_latency: got %0d expected 252", last_ready_cyc - sc); else n_pass++;
        n_total++; if (bus.IDLE !== 1'b1) $display("FAIL single_idle: got %b expected 1", bus.IDLE); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int r0, f0, sc;
        logic [7:0] exp_b [3];
        exp_b = '{8'h00, 8'hFF, 8'h55};
        r0 = ready_cnt; f0 = ferr_cnt; rx_q.delete();
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, 2600, -1, sc);
        bus.RXD = 1'b1;
        repeat (20) @(negedge clk);
        n_total++; if (ready_cnt - r0 != 3) $display("FAIL b2b_count: got %0d expected 3", ready_cnt - r0); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (rx_q.size() <= i || rx_q[i] !== exp_b[i])
                $display("FAIL b2b_data%0d: got %h expected %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_b[i]);
            else n_pass++;
        end
        n_total++; if (ferr_cnt != f0) $display("FAIL b2b_ferr: got %0d expected 0", ferr_cnt - f0); else n_pass++;
    endtask

    task automatic test_frame_err();
        int r0, f0, sc;
        r0 = ready_cnt; f0 = ferr_cnt; rx_q.delete();
        send_frame(8'h3C, 1'b0, 2600, -1, sc);
        repeat (200) begin @(negedge clk); bus.RXD = 1'b0; end
        n_total++; if (ferr_cnt - f0 != 1) $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); else n_pass++;
        n_total++; if (ready_cnt != r0) $display("FAIL ferr_ready: got %0d expected 0", ready_cnt - r0); else n_pass++;
        n_total++; if (bus.DATA !== 8'h55) $display("FAIL ferr_data_held: got %h expected 55", bus.DATA); else n_pass++;
        n_total++; if (bus.IDLE !== 1'b0) $display("FAIL ferr_brk_idle: got %b expected 0", bus.IDLE); else n_pass++;
        repeat (30) begin @(negedge clk); bus.RXD = 1'b1; end
        n_total++; if (bus.IDLE !== 1'b1) $display("FAIL ferr_brk_exit: got %b expected 1", bus.IDLE); else n_pass++;
        send_frame(8'h81, 1'b1, 2600, -1, sc);
        bus.RXD = 1'b1;
        repeat (20) @(negedge clk);
        n_total++; if (ready_cnt - r0 != 1) $display("FAIL ferr_next_count: got %0d expected 1", ready_cnt - r0); else n_pass++;
        n_total++; if (bus.DATA !== 8'h81) $display("FAIL ferr_next_data: got %h expected 81", bus.DATA); else n_pass++;
        n_total++; if (ferr_cnt - f0 != 1) $display("FAIL ferr_total: got %0d expected 1", ferr_cnt - f0); else n_pass++;
    endtask

    task automatic test_glitch();
        int r0, f0, idle_low;
        r0 = ready_cnt; f0 = ferr_cnt; idle_low = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.RXD = (c < 3) ? 1'b0 : 1'b1;
            if (bus.IDLE !== 1'b1) idle_low++;
        end
        n_total++; if (idle_low != 15) $display("FAIL glitch_start_len: got %0d expected 15", idle_low); else n_pass++;
        n_total++; if (bus.IDLE !== 1'b1) $display("FAIL glitch_idle: got %b expected 1", bus.IDLE); else n_pass++;
        n_total++; if (ready_cnt != r0 || ferr_cnt != f0)
            $display("FAIL glitch_strobe: got %0d/%0d expected 0/0", ready_cnt - r0, ferr_cnt - f0); else n_pass++;
    endtask

    task automatic test_skew();
        int r0, f0, sc;
        int per [2];
        per = '{2678, 2522};
        for (int i = 0; i < 2; i++) begin
            r0 = ready_cnt; f0 = ferr_cnt; rx_q.delete();
            send_frame(8'hFF, 1'b1, per[i], 4, sc);
            bus.RXD = 1'b1;
            repeat (40) @(negedge clk);
            n_total++;
            if (ready_cnt - r0 != 1 || bus.DATA !== 8'hFF)
                $display("FAIL skew_data p=%0d: got %h count %0d expected ff count 1", per[i], bus.DATA, ready_cnt - r0);
            else n_pass++;
            n_total++; if (ferr_cnt != f0) $display("FAIL skew_ferr p=%0d: got %0d expected 0", per[i], ferr_cnt - f0); else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        int r0, f0, sc, idle_low;
        r0 = ready_cnt; f0 = ferr_cnt; idle_low = 0; rx_q.delete();
        @(negedge clk); bus.RXD = 1'b0;
        repeat (26 * 5 + 13) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++; if (bus.DATA !== 8'h00) $display("FAIL rst_mid_data: got %h expected 00", bus.DATA); else n_pass++;
        n_total++; if (bus.IDLE !== 1'b1) $display("FAIL rst_mid_idle: got %b expected 1", bus.IDLE); else n_pass++;
        n_total++; if (bus.DATA_READY !== 1'b0 || bus.FRAME_ERR !== 1'b0)
            $display("FAIL rst_mid_strobes: got %b%b expected 00", bus.DATA_READY, bus.FRAME_ERR); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.IDLE !== 1'b1) idle_low++;
        end
        n_total++; if (idle_low != 0) $display("FAIL rst_low_line_start: got %0d busy cycles expected 0", idle_low); else n_pass++;
        n_total++; if (ready_cnt != r0 || ferr_cnt != f0)
            $display("FAIL rst_abort_strobe: got %0d/%0d expected 0/0", ready_cnt - r0, ferr_cnt - f0); else n_pass++;
        repeat (30) begin @(negedge clk); bus.RXD = 1'b1; end
        send_frame(8'h81, 1'b1, 2600, -1, sc);
        bus.RXD = 1'b1;
        repeat (20) @(negedge clk);
        n_total++; if (ready_cnt - r0 != 1 || bus.DATA !== 8'h81)
            $display("FAIL rst_after_frame: got %h count %0d expected 81 count 1", bus.DATA, ready_cnt - r0); else n_pass++;
    endtask

    task automatic test_loopback();
        int sc;
        logic [7:0] b;
        logic [7:0] exp_q[$];
        rx_q.delete();
        for (int i = 0; i < 64; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, 2600, -1, sc);
        end
        bus.RXD = 1'b1;
        repeat (20) @(negedge clk);
        n_total++; if (rx_q.size() != 64) $display("FAIL loop_count: got %0d expected 64", rx_q.size()); else n_pass++;
        for (int i = 0; i < 64; i++) begin
            n_total++;
            if (rx_q.size() <= i || rx_q[i] !== exp_q[i])
                $display("FAIL loop_byte%0d: got %h expected %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
    endtask

    initial begin
        bus.RXD = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_skew();
        test_reset_midframe();
        test_loopback();
        n_total++; if (both_cnt != 0) $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); else n_pass++;
        n_total++; if (wide_cnt != 0) $display("FAIL strobe_width: got %0d wide expected 0", wide_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
